seg7_pattern_decoder: RTL and testbench

- Inverse of the team's binary-to-seven-segment encoder: samples a 7-bit segment pattern (A..G, active-high) and recovers the 4-bit hex digit it represents.
- Requires the pattern to be stable for a programmable number of cycles before publishing. Glitches and transitional patterns never reach the output.
- Used in loopback self-test of display drivers and for reading segment buses from external boards.
- Flags blank (all-off) and illegal patterns separately from valid digits.

---
 rtl/seg7_pattern_decoder.sv | 150 +++++++++++++++
 tb/tb_seg7_pattern_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder.sv
// Seven-segment pattern decoder: recovers the hex digit from a segment bus
// once the pattern has been stable for STABLE_CYCLES samples.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Binary_Num,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Error,
  output logic       o_Locked
);

  typedef enum logic [1:0] {UNLOCKED, SETTLING, LOCKED} state_t;

  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(STABLE_CYCLES);

  logic [6:0]       pat;
  logic [6:0]       seg_q, seg_d;
  logic [6:0]       prev_q, prev_d;
  logic             seg_vld_q, seg_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  state_t           state_q, state_d;
  logic [3:0]       num_q, num_d;
  logic             valid_q, valid_d;
  logic             blank_q, blank_d;
  logic             error_q, error_d;
  logic             locked_q, locked_d;
  logic             take;
  logic             legal;
  logic [3:0]       digit;

  assign pat = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                i_Segment_E, i_Segment_F, i_Segment_G};

  always_comb begin
    legal = 1'b1;
    digit = 4'h0;
    case (seg_q)
      7'h7E: digit = 4'h0;
      7'h30: digit = 4'h1;
      7'h6D: digit = 4'h2;
      7'h79: digit = 4'h3;
      7'h33: digit = 4'h4;
      7'h5B: digit = 4'h5;
      7'h5F: digit = 4'h6;
      7'h70: digit = 4'h7;
      7'h7F: digit = 4'h8;
      7'h7B: digit = 4'h9;
      7'h77: digit = 4'hA;
      7'h1F: digit = 4'hB;
      7'h4E: digit = 4'hC;
      7'h3D: digit = 4'hD;
      7'h4F: digit = 4'hE;
      7'h47: digit = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    seg_d     = pat;
    seg_vld_d = 1'b1;
    prev_d    = seg_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    num_d     = num_q;
    valid_d   = 1'b0;
    blank_d   = blank_q;
    error_d   = error_q;
    locked_d  = locked_q;
    take      = 1'b0;
    cnt_n     = CNT_W'(1);

    // The sample register holds its reset value on the first edge after
    // release, so UNLOCKED waits for a real sample before counting.
    case (state_q)
      UNLOCKED: take = seg_vld_q;
      SETTLING: begin
        take = 1'b1;
        if (seg_q == prev_q) cnt_n = cnt_q + CNT_W'(1);
      end
      LOCKED:   take = (seg_q != prev_q);
      default:  take = 1'b0;
    endcase

    if (take) begin
      cnt_d    = cnt_n;
      state_d  = SETTLING;
      locked_d = 1'b0;
      if (cnt_n == LOCK_CNT) begin
        state_d  = LOCKED;
        locked_d = 1'b1;
        if (seg_q == 7'h00) begin
          blank_d = 1'b1;
          error_d = 1'b0;
        end else if (legal) begin
          num_d   = digit;
          valid_d = 1'b1;
          blank_d = 1'b0;
          error_d = 1'b0;
        end else begin
          blank_d = 1'b0;
          error_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      seg_q     <= 7'h00;
      prev_q    <= 7'h00;
      seg_vld_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= UNLOCKED;
      num_q     <= 4'h0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b0;
      error_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      prev_q    <= prev_d;
      seg_vld_q <= seg_vld_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      num_q     <= num_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      error_q   <= error_d;
      locked_q  <= locked_d;
    end
  end

  assign o_Binary_Num = num_q;
  assign o_Valid      = valid_q;
  assign o_Blank      = blank_q;
  assign o_Error      = error_q;
  assign o_Locked     = locked_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed bench for seg7_pattern_decoder with STABLE_CYCLES=4.
module tb_seg7_pattern_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sa, sb, sc, sd, se, sf, sg;
  logic [3:0] num;
  logic       valid, blank, error, locked;

  int checks = 0;
  int errors = 0;

  logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg7_pattern_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Segment_A(sa), .i_Segment_B(sb), .i_Segment_C(sc), .i_Segment_D(sd),
    .i_Segment_E(se), .i_Segment_F(sf), .i_Segment_G(sg),
    .o_Binary_Num(num), .o_Valid(valid), .o_Blank(blank),
    .o_Error(error), .o_Locked(locked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input logic [6:0] p);
    {sa, sb, sc, sd, se, sf, sg} = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_p(7'h6D);
    step();
    step();
    checks++;
    if ({num, valid, blank, error, locked} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got num=%0h v=%b b=%b e=%b l=%b, want all 0",
               num, valid, blank, error, locked);
    end
    rst = 1'b0;
  endtask

  // 7'h6D held from before reset release: lock on the 5th edge after release
  task automatic test_first_lock();
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (valid !== (k == 5) || locked !== (k >= 5)) begin
        errors++;
        $display("FAIL first_lock_timing k=%0d: got v=%b l=%b, want v=%b l=%b",
                 k, valid, locked, (k == 5), (k >= 5));
      end
      if (k == 5) begin
        checks++;
        if (num !== 4'h2 || blank !== 1'b0 || error !== 1'b0) begin
          errors++;
          $display("FAIL first_lock_value: got num=%0h b=%b e=%b, want num=2 b=0 e=0",
                   num, blank, error);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int low;
    for (int c = 0; c < 16; c++) begin
      low = 0;
      set_p(tbl[c]);
      for (int k = 1; k <= 6; k++) begin
        step();
        if (!locked) low++;
        checks++;
        if (valid !== (k == 5)) begin
          errors++;
          $display("FAIL sweep_valid code=%0d k=%0d: got %b want %b", c, k, valid, (k == 5));
        end
        if (k == 5) begin
          checks++;
          if (num !== c[3:0]) begin
            errors++;
            $display("FAIL sweep_digit: got %0h want %0h", num, c[3:0]);
          end
        end
      end
      checks++;
      if (low != 3) begin
        errors++;
        $display("FAIL sweep_locked_low code=%0d: got %0d cycles want 3", c, low);
      end
    end
  endtask

  task automatic test_glitch();
    int low;
    int pulses;
    set_p(7'h30);
    repeat (6) step();
    low = 0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      set_p((k <= 2) ? 7'h7F : 7'h30);
      step();
      if (!locked) low++;
      if (valid) pulses++;
      checks++;
      if (num !== 4'h1) begin
        errors++;
        $display("FAIL glitch_hold k=%0d: got num=%0h want 1", k, num);
      end
      checks++;
      if (valid !== (k == 7)) begin
        errors++;
        $display("FAIL glitch_relock k=%0d: got v=%b want %b", k, valid, (k == 7));
      end
    end
    checks++;
    if (low != 5 || pulses != 1) begin
      errors++;
      $display("FAIL glitch_counts: got low=%0d pulses=%0d want low=5 pulses=1", low, pulses);
    end
  endtask

  task automatic test_blank_error();
    int pulses;
    pulses = 0;
    set_p(7'h00);
    repeat (6) begin step(); if (valid) pulses++; end
    checks++;
    if (blank !== 1'b1 || error !== 1'b0 || num !== 4'h1 || locked !== 1'b1 || pulses != 0) begin
      errors++;
      $display("FAIL blank: got b=%b e=%b num=%0h l=%b pulses=%0d, want b=1 e=0 num=1 l=1 pulses=0",
               blank, error, num, locked, pulses);
    end
    set_p(7'h01);
    repeat (6) begin step(); if (valid) pulses++; end
    checks++;
    if (blank !== 1'b0 || error !== 1'b1 || num !== 4'h1 || locked !== 1'b1 || pulses != 0) begin
      errors++;
      $display("FAIL illegal: got b=%b e=%b num=%0h l=%b pulses=%0d, want b=0 e=1 num=1 l=1 pulses=0",
               blank, error, num, locked, pulses);
    end
  endtask

  task automatic test_reset_mid_settle();
    set_p(7'h79);
    repeat (3) step();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({num, valid, blank, error, locked} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got num=%0h v=%b b=%b e=%b l=%b, want all 0",
               num, valid, blank, error, locked);
    end
    #1 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (valid !== (k == 5) || locked !== (k >= 5)) begin
        errors++;
        $display("FAIL relock_after_reset k=%0d: got v=%b l=%b, want v=%b l=%b",
                 k, valid, locked, (k == 5), (k >= 5));
      end
    end
    checks++;
    if (num !== 4'h3) begin
      errors++;
      $display("FAIL relock_digit: got %0h want 3", num);
    end
  endtask

  task automatic test_toggle();
    for (int k = 1; k <= 50; k++) begin
      set_p(k[0] ? 7'h7E : 7'h30);
      step();
      checks++;
      if (valid !== 1'b0 || (k >= 2 && locked !== 1'b0) || num !== 4'h3) begin
        errors++;
        $display("FAIL toggle k=%0d: got v=%b l=%b num=%0h, want v=0 l=%b num=3",
                 k, valid, locked, num, (k < 2));
      end
    end
  endtask

  initial begin
    set_p(7'h00);
    test_reset();
    test_first_lock();
    test_sweep();
    test_glitch();
    test_blank_error();
    test_reset_mid_settle();
    test_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
